program_stream_decoder: RTL

//  Walks a packed program image in a sync 8-bit ROM record by record. Each record is

---
 rtl/program_stream_decoder.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/program_stream_decoder.sv
// Record walker for a packed program image held in a synchronous 8-bit ROM.
// Define PROG_DECODER_CHECKSUM_EN to require a trailing per-record checksum byte.
module program_stream_decoder #(
    parameter int         PROGRAM_SIZE   = 1,
    parameter int         PROG_ADDR_BITS = (PROGRAM_SIZE > 1) ? $clog2(PROGRAM_SIZE) : 1,
    parameter int         ADDR_BYTES     = 2,
    parameter int         LENGTH_BYTES   = 1,
    parameter int         MAX_BLOCK_LEN  = 64,
    parameter logic [7:0] EOF_TYPE       = 8'h01
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [PROG_ADDR_BITS-1:0]            prog_addr,
    input  logic [7:0]                           prog_data,
    input  logic                                 start,
    output logic                                 ready,
    output logic                                 done,
    output logic                                 eop,
    output logic                                 error,
    output logic                                 hdr_valid,
    output logic [8*LENGTH_BYTES-1:0]            block_length,
    output logic [8*ADDR_BYTES-1:0]              block_address,
    output logic [7:0]                           block_type,
    output logic                                 data_valid,
    input  logic                                 data_ready,
    output logic [7:0]                           data_byte,
    output logic [$clog2(MAX_BLOCK_LEN+1)-1:0]   data_index,
    output logic                                 data_last
);

    localparam int LW  = 8 * LENGTH_BYTES;
    localparam int AW  = 8 * ADDR_BYTES;
    localparam int IW  = $clog2(MAX_BLOCK_LEN + 1);
    localparam int PAW = PROG_ADDR_BITS + 1;

    localparam logic [2:0]     LEN_END    = 3'(LENGTH_BYTES);
    localparam logic [2:0]     TYPE_IDX   = 3'(LENGTH_BYTES + ADDR_BYTES);
    localparam logic [PAW-1:0] ADDR_LIMIT = PAW'(PROGRAM_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        HDR,
        DATA,
`ifdef PROG_DECODER_CHECKSUM_EN
        CSUM,
`endif
        FINISH
    } state_t;

    // Which part of the record the pending FETCH/CAPTURE pair is reading.
    typedef enum logic [1:0] {
        PH_HDR,
        PH_DATA,
        PH_CSUM
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    // NOTE: one extra bit so the pointer can sit at PROGRAM_SIZE and be caught as an overrun instead of wrapping.
    logic [PAW-1:0]  addr_q, addr_d;
    logic [2:0]      hcnt_q, hcnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [AW-1:0]   baddr_q, baddr_d;
    logic [7:0]      type_q, type_d;
    logic [7:0]      byte_q, byte_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      sum_q, sum_d;
    logic            done_q, done_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            end_rec, close_rec, close_err;

    assign prog_addr     = addr_q[PROG_ADDR_BITS-1:0];
    assign ready         = ready_q;
    assign done          = done_q;
    assign eop           = eop_q;
    assign error         = err_q;
    assign hdr_valid     = (state_q == HDR);
    assign block_length  = len_q;
    assign block_address = baddr_q;
    assign block_type    = type_q;
    assign data_valid    = (state_q == DATA);
    assign data_byte     = byte_q;
    assign data_index    = idx_q;
    assign data_last     = (state_q == DATA) && (LW'(idx_q) == len_q - LW'(1));

    // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        addr_d    = addr_q;
        hcnt_d    = hcnt_q;
        len_d     = len_q;
        baddr_d   = baddr_q;
        type_d    = type_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        done_d    = done_q;
        eop_d     = eop_q;
        err_d     = err_q;
        end_rec   = 1'b0;
        close_rec = 1'b0;
        close_err = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start && ready_q) begin
                    state_d = FETCH;
                    phase_d = PH_HDR;
                    hcnt_d  = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                    done_d  = 1'b0;
                    eop_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                if (addr_q == ADDR_LIMIT) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    eop_d   = 1'b1;
                    err_d   = 1'b1;
                    addr_d  = '0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                addr_d = addr_q + PAW'(1);
                sum_d  = sum_q + prog_data;
                case (phase_q)
                    PH_HDR: begin
                        if (hcnt_q < LEN_END)       len_d   = LW'({len_q, prog_data});
                        else if (hcnt_q < TYPE_IDX) baddr_d = AW'({baddr_q, prog_data});
                        else                        type_d  = prog_data;
                        hcnt_d  = hcnt_q + 3'd1;
                        state_d = (hcnt_q == TYPE_IDX) ? HDR : FETCH;
                    end
                    PH_DATA: begin
                        byte_d  = prog_data;
                        state_d = DATA;
                    end
                    default: begin
`ifdef PROG_DECODER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
`endif
                    end
                endcase
            end
            HDR: begin
                if (int'(len_q) > MAX_BLOCK_LEN) begin
                    close_rec = 1'b1;
                    close_err = 1'b1;
                end else if (len_q == '0) begin
                    end_rec = 1'b1;
                end else begin
                    state_d = FETCH;
                    phase_d = PH_DATA;
                end
            end
            DATA: begin
                if (data_ready) begin
                    if (data_last) begin
                        end_rec = 1'b1;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = FETCH;
                    end
                end
            end
`ifdef PROG_DECODER_CHECKSUM_EN
            CSUM: begin
                close_rec = 1'b1;
                close_err = (sum_q != 8'h00);
            end
`endif
            default: state_d = IDLE;
        endcase

        if (end_rec) begin
`ifdef PROG_DECODER_CHECKSUM_EN
            state_d = FETCH;
            phase_d = PH_CSUM;
`else
            close_rec = 1'b1;
`endif
        end

        // An EOF record rewinds the pointer so the next start replays the image.
        if (close_rec) begin
            state_d = FINISH;
            done_d  = 1'b1;
            err_d   = close_err;
            eop_d   = (type_q == EOF_TYPE);
            if (eop_d) addr_d = '0;
        end

        ready_d = (state_d == IDLE) || (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_HDR;
            addr_q  <= '0;
            hcnt_q  <= '0;
            len_q   <= '0;
            baddr_q <= '0;
            type_q  <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            hcnt_q  <= hcnt_d;
            len_q   <= len_d;
            baddr_q <= baddr_d;
            type_q  <= type_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

endmodule
